// File: rtl/alu_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arb_pkg : shared ALU codes, FSM encoding and request bundle type.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_share_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SLL = 4'b0011;
    localparam logic [3:0] ALU_CTRL_SRL = 4'b0100;
    localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTRL_XOR = 4'b1000;
    localparam logic [3:0] ALU_CTRL_SRA = 4'b1001;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      shamt;
        logic [3:0]      aluctrl;
        logic [6:0]      op;
    } alu_req_t;

    function automatic logic is_zero(input logic [XLEN-1:0] v);
        return (v == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_arb_if.sv
// ---------------------------------------------------------------------------
// alu_share_arb_if : request, ALU-bus and response channels of the arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_share_arb_if;
    import alu_share_arb_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [4:0]      req0_shamt;
    logic [3:0]      req0_aluctrl;
    logic [6:0]      req0_op;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [4:0]      req1_shamt;
    logic [3:0]      req1_aluctrl;
    logic [6:0]      req1_op;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_shamt;
    logic [3:0]      alu_aluctrl;
    logic [6:0]      alu_op;
    logic [XLEN-1:0] alu_aluout;
    logic            alu_overflow;
    logic            alu_lt;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_overflow;
    logic            rsp_lt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_shamt, req0_aluctrl, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_shamt, req1_aluctrl, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_shamt, alu_aluctrl, alu_op,
        input  alu_aluout, alu_overflow, alu_lt,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_lt,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_shamt, req0_aluctrl, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_shamt, req1_aluctrl, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_shamt, alu_aluctrl, alu_op,
        output alu_aluout, alu_overflow, alu_lt,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_lt,
        output rsp_ready
    );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-input round-robin picker; last_grant resets to 1 (req0 first).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic en_i,
    input  wire logic req0_i,
    input  wire logic req1_i,
    output logic      grant0_o,
    output logic      grant1_o
);

    logic last_grant_q;

    // On a tie, the requester that did not win last time goes first.
    assign grant0_o = en_i & req0_i & (~req1_i | last_grant_q);
    assign grant1_o = en_i & req1_i & (~req0_i | ~last_grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (grant0_o | grant1_o) begin
            last_grant_q <= grant1_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb : time-shares one ALU between two requesters, tagged response.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_share_arb
    import alu_share_arb_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        flush_i,
    output logic             busy_o,
    alu_share_arb_if.slave   bus
);

    state_e          state_q;
    alu_req_t        alu_q;
    alu_req_t        alu_d;
    logic            id_q;
    logic            busy_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_zero_q;
    logic            rsp_overflow_q;
    logic            rsp_lt_q;

    logic            win_open;
    logic            grant0;
    logic            grant1;
    logic            accept;

    // Readies also drop during reset so every output reads 0 while it is held.
    assign win_open = ~reset & ~flush_i &
                      ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     (win_open),
        .req0_i   (bus.req0_valid),
        .req1_i   (bus.req1_valid),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign accept         = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        alu_d = '{a: bus.req0_a, b: bus.req0_b, shamt: bus.req0_shamt,
                  aluctrl: bus.req0_aluctrl, op: bus.req0_op};
        if (grant1) begin
            alu_d = '{a: bus.req1_a, b: bus.req1_b, shamt: bus.req1_shamt,
                      aluctrl: bus.req1_aluctrl, op: bus.req1_op};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            alu_q          <= '0;
            id_q           <= 1'b0;
            busy_q         <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_lt_q       <= 1'b0;
        end else if (flush_i) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        alu_q   <= alu_d;
                        id_q    <= grant1;
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q   <= bus.alu_aluout;
                    rsp_zero_q     <= is_zero(bus.alu_aluout);
                    rsp_overflow_q <= bus.alu_overflow;
                    rsp_lt_q       <= bus.alu_lt;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (accept) begin
                            alu_q   <= alu_d;
                            id_q    <= grant1;
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a        = alu_q.a;
    assign bus.alu_b        = alu_q.b;
    assign bus.alu_shamt    = alu_q.shamt;
    assign bus.alu_aluctrl  = alu_q.aluctrl;
    assign bus.alu_op       = alu_q.op;

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_lt       = rsp_lt_q;
    assign busy_o           = busy_q;

endmodule

`default_nettype wire
